wb_port_arbiter: RTL

Write-back port arbiter for the superscalar result memory. NREQ functional-unit requesters compete each cycle for the memory's two write ports (port 0, port 1). Fairness comes from a rotating round-robin pointer. A grant never lets both ports write the same address in one cycle. The block sits between the execute-stage result buses and the result memory, and drives the memory's data0/data1, addr0/addr1 and rw0/rw1 inputs directly from registers.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_rr_pick.sv | 34 +++
 rtl/wb_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back port arbiter.
//   WB_WORDSIZE / WB_ADDRSIZE / WB_NREQ : default result width, address width,
//                                         requester count
//   wb_port_t                           : one write-port bundle (valid, addr, data)
//   ptr_inc(ptr, n)                     : round-robin pointer increment modulo n
package wb_pkg;

    localparam int WB_WORDSIZE = 16;
    localparam int WB_ADDRSIZE = 5;
    localparam int WB_NREQ     = 4;

    typedef struct packed {
        logic                   valid;
        logic [WB_ADDRSIZE-1:0] addr;
        logic [WB_WORDSIZE-1:0] data;
    } wb_port_t;

    // Modulo-n increment; 4 bits covers every index for n up to 8.
    function automatic logic [3:0] ptr_inc(input logic [3:0] ptr, input logic [3:0] n);
        logic [3:0] nxt;
        if (ptr == (n - 4'd1)) begin
            nxt = 4'd0;
        end else begin
            nxt = ptr + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: rotated find-first-set.
//   valid   in  N   candidate mask
//   start   in  IW  index the scan begins at (wraps modulo N)
//   exclude in  N   indices that may not be picked
//   found   out 1   some index was eligible
//   idx     out IW  first eligible index in scan order
module wb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  exclude,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0] cand_s;

    assign cand_s = valid & ~exclude;

    // Walk the candidates from start; the first hit wins and later hits are ignored.
    always_comb begin
        found = 1'b0;
        idx   = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            int j;
            j     = (int'(start) + k) % N;
            idx   = (!found && cand_s[j]) ? IW'(j) : idx;
            found = found | cand_s[j];
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter placing up to two requester results per
// cycle onto the two write ports of the result memory.
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid  [NREQ]   requester i has a result pending
//   req_data/req_addr   per-requester result and destination, slice i
//   req_ready  [NREQ]   combinational grant (zero while in reset)
//   data0/1, addr0/1    registered write data / address for ports 0 and 1
//   rw0/1               registered write enables
// Optional build macro WB_PORT_STATS_EN adds saturating 16-bit counters
//   conflict_cnt (cycles with a same-address skip) and stall_cnt (cycles with
//   a valid requester left waiting).
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int wordsize = WB_WORDSIZE,
    parameter int addrsize = WB_ADDRSIZE,
    parameter int NREQ     = WB_NREQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*wordsize-1:0] req_data,
    input  logic [NREQ*addrsize-1:0] req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [wordsize-1:0]      data0,
    output logic [wordsize-1:0]      data1,
    output logic [addrsize-1:0]      addr0,
    output logic [addrsize-1:0]      addr1,
    output logic                     rw0,
    output logic                     rw1
`ifdef WB_PORT_STATS_EN
    ,
    output logic [15:0]              conflict_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]       rr_ptr_r;
    logic                p0_found_s;
    logic [IW-1:0]       p0_idx_s;
    logic                p1_found_s;
    logic [IW-1:0]       p1_idx_s;
    logic [NREQ-1:0]     excl_s;
    logic [NREQ-1:0]     same_s;
    logic [IW-1:0]       last_s;
    logic [addrsize-1:0] p0_addr_s;

    wb_rr_pick #(.N(NREQ), .IW(IW)) u_pick0 (
        .valid   (req_valid),
        .start   (rr_ptr_r),
        .exclude ({NREQ{1'b0}}),
        .found   (p0_found_s),
        .idx     (p0_idx_s)
    );

    assign p0_addr_s = req_addr[int'(p0_idx_s)*addrsize +: addrsize];

    // Pick 1 scans from rr_ptr too, so everything up to and including pick 0
    // (in rotated order) is masked; that also stops the scan before wrapping
    // back to rr_ptr. Same-address requesters are masked so they wait.
    always_comb begin
        int p0_off;
        excl_s = {NREQ{1'b0}};
        same_s = {NREQ{1'b0}};
        p0_off = (int'(p0_idx_s) - int'(rr_ptr_r) + NREQ) % NREQ;
        for (int j = 0; j < NREQ; j++) begin
            int off_j;
            off_j     = (j - int'(rr_ptr_r) + NREQ) % NREQ;
            same_s[j] = p0_found_s && req_valid[j] && (IW'(j) != p0_idx_s)
                        && (req_addr[j*addrsize +: addrsize] == p0_addr_s);
            excl_s[j] = (off_j <= p0_off) || same_s[j];
        end
    end

    wb_rr_pick #(.N(NREQ), .IW(IW)) u_pick1 (
        .valid   (req_valid),
        .start   (rr_ptr_r),
        .exclude (excl_s),
        .found   (p1_found_s),
        .idx     (p1_idx_s)
    );

    assign last_s = p1_found_s ? p1_idx_s : p0_idx_s;

    // Grant decode, forced to zero while reset is asserted.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (!rst_n) begin
            req_ready = {NREQ{1'b0}};
        end else begin
            if (p0_found_s) begin
                req_ready[p0_idx_s] = 1'b1;
            end else begin
                req_ready[p0_idx_s] = 1'b0;
            end
            if (p1_found_s) begin
                req_ready[p1_idx_s] = 1'b1;
            end else begin
                req_ready[p1_idx_s] = req_ready[p1_idx_s];
            end
        end
    end

    // Output port registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw0      <= 1'b0;
            rw1      <= 1'b0;
            data0    <= {wordsize{1'b0}};
            data1    <= {wordsize{1'b0}};
            addr0    <= {addrsize{1'b0}};
            addr1    <= {addrsize{1'b0}};
            rr_ptr_r <= {IW{1'b0}};
        end else begin
            rw0 <= p0_found_s;
            rw1 <= p1_found_s;
            if (p0_found_s) begin
                data0    <= req_data[int'(p0_idx_s)*wordsize +: wordsize];
                addr0    <= p0_addr_s;
                rr_ptr_r <= IW'(ptr_inc(4'(last_s), 4'(NREQ)));
            end
            if (p1_found_s) begin
                data1 <= req_data[int'(p1_idx_s)*wordsize +: wordsize];
                addr1 <= req_addr[int'(p1_idx_s)*addrsize +: addrsize];
            end
        end
    end

`ifdef WB_PORT_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= 16'd0;
            stall_cnt    <= 16'd0;
        end else begin
            if ((|same_s) && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if ((|(req_valid & ~req_ready)) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built; arbitration is unaffected.
`endif

endmodule
